// File: rtl/mesh_xbar_router.sv
// Packet switch for ROWS*COLS terminals: input FIFOs, round-robin crossbar, FWFT output FIFOs.
// Optional simulation trace of transfers and drops when MESH_XBAR_DEBUG_EN is defined.
module mesh_xbar_router #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ROWS*COLS-1:0]           pndng_i_in,
    input  logic [ROWS*COLS*pckg_sz-1:0]   data_out_i_in,
    output logic [ROWS*COLS-1:0]           popin,
    output logic [ROWS*COLS-1:0]           pndng,
    output logic [ROWS*COLS*pckg_sz-1:0]   data_out,
    input  logic [ROWS*COLS-1:0]           pop
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = $clog2(fifo_depth + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(fifo_depth);

    logic [pckg_sz-1:0] in_mem_q  [N][fifo_depth];
    logic [pckg_sz-1:0] in_mem_d  [N][fifo_depth];
    logic [pckg_sz-1:0] out_mem_q [N][fifo_depth];
    logic [pckg_sz-1:0] out_mem_d [N][fifo_depth];
    logic [PW-1:0]      in_rd_q [N], in_rd_d [N], in_wr_q [N], in_wr_d [N];
    logic [PW-1:0]      out_rd_q[N], out_rd_d[N], out_wr_q[N], out_wr_d[N];
    logic [CW-1:0]      in_cnt_q [N], in_cnt_d [N];
    logic [CW-1:0]      out_cnt_q[N], out_cnt_d[N];
    logic [IW-1:0]      arb_ptr_q[N], arb_ptr_d[N];

    logic [pckg_sz-1:0] head     [N];
    logic               head_vld [N];
    logic               head_bad [N];
    logic [IW-1:0]      head_dst [N];
    logic               in_pop   [N];
    logic               out_push [N];
    logic               out_pop  [N];
    logic [IW-1:0]      out_src  [N];

    // Pointers wrap at fifo_depth, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(fifo_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic int rr_idx(input logic [IW-1:0] base, input int off);
        return (int'(base) + off) % N;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            popin[i]    = pndng_i_in[i] && (in_cnt_q[i] != FULL_CNT) && !reset;
            head[i]     = in_mem_q[i][in_rd_q[i]];
            head_vld[i] = (in_cnt_q[i] != '0);
            head_bad[i] = head_vld[i] &&
                          ((int'(head[i][pckg_sz-9 -: 4]) >= ROWS) ||
                           (int'(head[i][pckg_sz-13 -: 4]) >= COLS));
            head_dst[i] = IW'(int'(head[i][pckg_sz-9 -: 4]) * COLS +
                              int'(head[i][pckg_sz-13 -: 4]));
        end
    end

    // Invalid heads are dropped unconditionally; valid heads compete per output.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_pop[i] = head_bad[i];
        end
        for (int j = 0; j < N; j++) begin
            out_push[j]  = 1'b0;
            out_src[j]   = '0;
            arb_ptr_d[j] = arb_ptr_q[j];
            if (out_cnt_q[j] != FULL_CNT) begin
                for (int off = 0; off < N; off++) begin
                    if (!out_push[j] && head_vld[rr_idx(arb_ptr_q[j], off)] &&
                        !head_bad[rr_idx(arb_ptr_q[j], off)] &&
                        (head_dst[rr_idx(arb_ptr_q[j], off)] == IW'(j))) begin
                        out_push[j]                       = 1'b1;
                        out_src[j]                        = IW'(rr_idx(arb_ptr_q[j], off));
                        in_pop[rr_idx(arb_ptr_q[j], off)] = 1'b1;
                    end
                end
                if (out_push[j]) begin
                    arb_ptr_d[j] = (out_src[j] == IW'(N - 1)) ? '0 : out_src[j] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_mem_d  = in_mem_q;
        out_mem_d = out_mem_q;
        for (int i = 0; i < N; i++) begin
            in_wr_d[i]  = in_wr_q[i];
            in_rd_d[i]  = in_rd_q[i];
            in_cnt_d[i] = in_cnt_q[i];
            if (popin[i]) begin
                in_mem_d[i][in_wr_q[i]] = data_out_i_in[i*pckg_sz +: pckg_sz];
                in_wr_d[i]              = ptr_inc(in_wr_q[i]);
            end
            if (in_pop[i]) begin
                in_rd_d[i] = ptr_inc(in_rd_q[i]);
            end
            if (popin[i] && !in_pop[i]) begin
                in_cnt_d[i] = in_cnt_q[i] + 1'b1;
            end else if (!popin[i] && in_pop[i]) begin
                in_cnt_d[i] = in_cnt_q[i] - 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            out_wr_d[j]  = out_wr_q[j];
            out_rd_d[j]  = out_rd_q[j];
            out_cnt_d[j] = out_cnt_q[j];
            out_pop[j]   = pop[j] && (out_cnt_q[j] != '0);
            if (out_push[j]) begin
                out_mem_d[j][out_wr_q[j]] = head[out_src[j]];
                out_wr_d[j]               = ptr_inc(out_wr_q[j]);
            end
            if (out_pop[j]) begin
                out_rd_d[j] = ptr_inc(out_rd_q[j]);
            end
            if (out_push[j] && !out_pop[j]) begin
                out_cnt_d[j] = out_cnt_q[j] + 1'b1;
            end else if (!out_push[j] && out_pop[j]) begin
                out_cnt_d[j] = out_cnt_q[j] - 1'b1;
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int j = 0; j < N; j++) begin
            pndng[j] = (out_cnt_q[j] != '0);
            if (out_cnt_q[j] != '0) begin
                data_out[j*pckg_sz +: pckg_sz] = out_mem_q[j][out_rd_q[j]];
            end
        end
    end

    // Storage is not reset; emptiness is carried entirely by the counters.
    always_ff @(posedge clk) begin
        in_mem_q  <= in_mem_d;
        out_mem_q <= out_mem_d;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                in_rd_q[i]   <= '0;
                in_wr_q[i]   <= '0;
                in_cnt_q[i]  <= '0;
                out_rd_q[i]  <= '0;
                out_wr_q[i]  <= '0;
                out_cnt_q[i] <= '0;
                arb_ptr_q[i] <= '0;
            end
        end else begin
            in_rd_q   <= in_rd_d;
            in_wr_q   <= in_wr_d;
            in_cnt_q  <= in_cnt_d;
            out_rd_q  <= out_rd_d;
            out_wr_q  <= out_wr_d;
            out_cnt_q <= out_cnt_d;
            arb_ptr_q <= arb_ptr_d;
        end
    end

`ifdef MESH_XBAR_DEBUG_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < N; j++) begin
                if (out_push[j]) begin
                    $display("%0t mesh_xbar_router xfer src=%0d dst=%0d pkt=%h",
                             $time, out_src[j], j, head[out_src[j]]);
                end
                if (head_bad[j]) begin
                    $display("%0t mesh_xbar_router drop src=%0d row=%0d col=%0d pkt=%h",
                             $time, j, head[j][pckg_sz-9 -: 4], head[j][pckg_sz-13 -: 4], head[j]);
                end
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_mesh_xbar_router.sv
// Randomized and directed bench for mesh_xbar_router against a queue-based reference model.
module tb_mesh_xbar_router;

    localparam int P = 40;
    localparam int D = 4;
    localparam int R = 4;
    localparam int C = 4;
    localparam int N = R * C;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     pndng_i_in, popin, pndng, pop;
    logic [N*P-1:0]   data_out_i_in, data_out;

    always #5 clk = ~clk;

    mesh_xbar_router #(.pckg_sz(P), .fifo_depth(D), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .reset(reset), .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in),
        .popin(popin), .pndng(pndng), .data_out(data_out), .pop(pop)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [P-1:0] src_q [N][$];
    logic [P-1:0] m_in  [N][$];
    logic [P-1:0] m_out [N][$];
    int           m_ptr [N];
    logic [P-1:0] got_q [$];
    int           mon_j = 0;
    logic [P-1:0] rp;
    logic [P-1:0] lb [N];

    task automatic chk(input string tag, input logic [N*P-1:0] got, input logic [N*P-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int dst_of(input logic [P-1:0] p);
        if (int'(p[P-9 -: 4]) >= R || int'(p[P-13 -: 4]) >= C) return -1;
        return int'(p[P-9 -: 4]) * C + int'(p[P-13 -: 4]);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            pndng_i_in[i] = (src_q[i].size() > 0);
            data_out_i_in[i*P +: P] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] pin);
        logic [N-1:0] gnt;
        logic [N-1:0] opush;
        logic [P-1:0] opkt [N];
        gnt = '0;
        opush = '0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_in[i].delete();
                m_out[i].delete();
                m_ptr[i] = 0;
            end
            return;
        end
        for (int j = 0; j < N; j++) begin
            opkt[j] = '0;
            if (m_out[j].size() < D) begin
                for (int off = 0; off < N; off++) begin
                    int k;
                    k = (m_ptr[j] + off) % N;
                    if (!opush[j] && m_in[k].size() > 0 && dst_of(m_in[k][0]) == j) begin
                        opush[j] = 1'b1;
                        opkt[j]  = m_in[k][0];
                        gnt[k]   = 1'b1;
                        m_ptr[j] = (k + 1) % N;
                    end
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            if (pop[j] && m_out[j].size() > 0) void'(m_out[j].pop_front());
            if (opush[j]) m_out[j].push_back(opkt[j]);
        end
        for (int i = 0; i < N; i++) begin
            if (m_in[i].size() > 0 && (dst_of(m_in[i][0]) < 0 || gnt[i])) void'(m_in[i].pop_front());
            if (pin[i]) m_in[i].push_back(data_out_i_in[i*P +: P]);
        end
    endtask

    task automatic cycle();
        logic [N-1:0]   ep, en, take;
        logic [N*P-1:0] ed;
        @(negedge clk);
        ed = '0;
        for (int i = 0; i < N; i++) begin
            ep[i] = pndng_i_in[i] && (m_in[i].size() < D) && !reset;
            en[i] = (m_out[i].size() > 0);
            if (en[i]) ed[i*P +: P] = m_out[i][0];
        end
        chk("popin", popin, ep);
        chk("pndng", pndng, en);
        chk("data_out", data_out, ed);
        if (pop[mon_j] && pndng[mon_j]) got_q.push_back(data_out[mon_j*P +: P]);
        take = popin;
        model_step(ep);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (take[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        pop = '0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive();
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pop = '0;
        pndng_i_in = '0;
        data_out_i_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pndng", pndng, '0);
        chk("rst_data", data_out, '0);
        chk("rst_popin", popin, '0);
        reset_dut();

        // Unicast 0 -> 6
        src_q[0].push_back(40'h0012ABCDEF);
        drive();
        #1;
        chk("uni_popin_hi", popin[0], 1'b1);
        cycle();
        chk("uni_popin_lo", popin[0], 1'b0);
        cycle();
        chk("uni_pndng6", pndng, 16'h0040);
        chk("uni_data6", data_out[6*P +: P], 40'h0012ABCDEF);
        pop[6] = 1'b1;
        cycle();
        pop[6] = 1'b0;
        chk("uni_clear6", pndng[6], 1'b0);

        // Contention on output 5, then second round from priority 4
        reset_dut();
        mon_j = 5;
        got_q.delete();
        pop[5] = 1'b1;
        for (int i = 1; i <= 3; i++) src_q[i].push_back(40'h0011000000 + 40'(i));
        drive();
        run(6);
        chk("cont_cnt1", 32'(got_q.size()), 32'd3);
        for (int n = 0; n < 3 && n < got_q.size(); n++) chk("cont_ord1", got_q[n], 40'h0011000001 + 40'(n));
        got_q.delete();
        src_q[0].push_back(40'h00110000A0);
        src_q[2].push_back(40'h00110000A2);
        src_q[4].push_back(40'h00110000A4);
        drive();
        run(6);
        chk("cont_cnt2", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("cont_ord2a", got_q[0], 40'h00110000A4);
            chk("cont_ord2b", got_q[1], 40'h00110000A0);
            chk("cont_ord2c", got_q[2], 40'h00110000A2);
        end
        pop[5] = 1'b0;

        // Backpressure 0 -> 15
        reset_dut();
        for (int n = 0; n < 9; n++) src_q[0].push_back(40'h00330000F0 + 40'(n));
        drive();
        run(14);
        chk("bp_pndng15", pndng, 16'h8000);
        chk("bp_popin_lo", popin[0], 1'b0);
        chk("bp_head", data_out[15*P +: P], 40'h00330000F0);
        mon_j = 15;
        got_q.delete();
        pop[15] = 1'b1;
        for (int t = 0; t < 60 && got_q.size() < 9; t++) cycle();
        pop[15] = 1'b0;
        chk("bp_cnt", 32'(got_q.size()), 32'd9);
        for (int n = 0; n < 9 && n < got_q.size(); n++) chk("bp_order", got_q[n], 40'h00330000F0 + 40'(n));

        // Invalid destination from terminal 4, then a valid one
        src_q[4].push_back(40'h0050123456);
        drive();
        #1;
        chk("inv_popin", popin[4], 1'b1);
        run(4);
        chk("inv_pndng", pndng, '0);
        src_q[4].push_back(40'h0021654321);
        drive();
        run(2);
        chk("inv_next_pndng", pndng, 16'h0200);
        chk("inv_next_data", data_out[9*P +: P], 40'h0021654321);
        pop[9] = 1'b1;
        cycle();
        pop[9] = 1'b0;

        // Reset mid-traffic
        reset_dut();
        for (int n = 0; n < 3; n++) src_q[0].push_back(40'h00120000C0 + 40'(n));
        drive();
        run(6);
        chk("mr_loaded", pndng, 16'h0040);
        src_q[1].push_back(40'h00120000D1);
        reset = 1'b1;
        drive();
        #1;
        chk("mr_popin", popin, '0);
        cycle();
        chk("mr_pndng", pndng, '0);
        chk("mr_data", data_out, '0);
        reset = 1'b0;
        drive();
        #1;
        run(2);
        chk("mr_after_pndng", pndng, 16'h0040);
        chk("mr_after_data", data_out[6*P +: P], 40'h00120000D1);

        // Loopback on all terminals
        reset_dut();
        for (int i = 0; i < N; i++) begin
            lb[i] = {8'hA5, 4'(i / C), 4'(i % C), 24'(i * 4097)};
            src_q[i].push_back(lb[i]);
        end
        drive();
        run(2);
        chk("lb_pndng", pndng, 16'hFFFF);
        for (int i = 0; i < N; i++) chk("lb_data", data_out[i*P +: P], lb[i]);

        // Randomized traffic with one mid-run reset
        reset_dut();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0 && src_q[i].size() < 3) begin
                    rp[31:0]  = $urandom;
                    rp[39:32] = 8'($urandom_range(0, 255));
                    rp[31:28] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 1));
                    rp[27:24] = 4'($urandom_range(0, 4));
                    src_q[i].push_back(rp);
                end
            end
            pop = 16'($urandom & $urandom);
            reset = (cyc == 1200);
            drive();
            cycle();
        end
        reset = 1'b0;
        pop = '1;
        run(60);
        chk("drain_pndng", pndng, '0);
        chk("drain_data", data_out, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
